// File: rtl/sample_collector_pkg.sv
// Shared definitions for the sample collector: bus address layout, entry
// packing and FSM state encoding.
package sample_collector_pkg;
  localparam int ADDR_W                = 19;
  localparam int PC_WIN                = 256;
  localparam int DEF_SAMPLE_REG_OFFSET = 7;
  localparam int TS_W                  = 16;
  localparam int ENTRY_W               = 32;
  localparam int E_TS_LSB              = 16;
  localparam int E_PIN_LSB             = 8;
  localparam int E_PIN_W               = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_WAIT} state_t;

  // [31:16] sweep timestamp, [15:8] pin index, [7:1] zero, [0] sample bit
  function automatic logic [ENTRY_W-1:0] make_entry(input logic [TS_W-1:0] ts,
                                                    input logic [E_PIN_W-1:0] pin,
                                                    input logic smp);
    return {ts, pin, 7'b0, smp};
  endfunction

  // Each pin controller owns a PC_WIN-byte window indexed by pin position.
  function automatic logic [ADDR_W-1:0] pin_addr(input logic [7:0] idx,
                                                 input logic [7:0] off);
    return {3'b0, idx, off};
  endfunction
endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through FIFO; a full FIFO still accepts a push when a pop
// retires the head in the same cycle, otherwise the push is reported as dropped.
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/sample_collector.sv
// Periodic sweeper of the pin-controller sample registers; stamps each enabled
// pin's sample with index and sweep timestamp and queues it for the host.
module sample_collector
  import sample_collector_pkg::*;
#(
  parameter int NUM_PINS          = 16,
  parameter int FIFO_DEPTH        = 64,
  parameter int SAMPLE_REG_OFFSET = DEF_SAMPLE_REG_OFFSET
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stop,
  input  logic [15:0]                   poll_period,
  input  logic [NUM_PINS-1:0]           pin_mask,
  output logic [ADDR_W-1:0]             pc_addr,
  output logic                          pc_rd,
  input  logic [15:0]                   pc_data,
  input  logic                          fifo_rd,
  output logic [ENTRY_W-1:0]            fifo_data,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clear_overflow,
  output logic                          busy
);
  state_t            state, state_nxt;
  logic [7:0]        idx;
  logic [15:0]       wait_cnt;
  logic [TS_W-1:0]   ts, sweep_ts, cur_ts;
  logic [255:0]      mask_ext;
  logic              last_pin, push, drop, fifo_full;
  logic [ENTRY_W-1:0] entry;
  logic              unused_data;

  assign mask_ext    = 256'(pin_mask);
  assign last_pin    = (idx == 8'(NUM_PINS-1));
  assign push        = pc_rd && !stop;
  // idx 0 is the first cycle of a sweep, so it sees the live timestamp
  assign cur_ts      = (idx == 8'd0) ? ts : sweep_ts;
  assign entry       = make_entry(cur_ts, idx, pc_data[0]);
  assign unused_data = ^pc_data[15:1];

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop) state_nxt = ST_IDLE;
    else begin
      case (state)
        ST_IDLE:  if (start) state_nxt = ST_SWEEP;
        ST_SWEEP: if (last_pin) state_nxt = (poll_period == 16'd0) ? ST_SWEEP : ST_WAIT;
        ST_WAIT:  if (wait_cnt <= 16'd1) state_nxt = ST_SWEEP;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pc_rd   = 1'b0;
    pc_addr = '0;
    busy    = (state != ST_IDLE);
    if (state == ST_SWEEP) begin
      pc_rd   = mask_ext[idx];
      pc_addr = pin_addr(idx, 8'(SAMPLE_REG_OFFSET));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= '0;
      wait_cnt <= '0;
      ts       <= '0;
      sweep_ts <= '0;
      overflow <= 1'b0;
    end else begin
      ts  <= ts + 1'b1;
      idx <= (state == ST_SWEEP && !last_pin && !stop) ? idx + 1'b1 : 8'd0;
      if (state == ST_SWEEP && idx == 8'd0) sweep_ts <= ts;
      if (state == ST_SWEEP && last_pin)    wait_cnt <= poll_period;
      else if (state == ST_WAIT)            wait_cnt <= wait_cnt - 1'b1;
      if (drop)                 overflow <= 1'b1;
      else if (clear_overflow)  overflow <= 1'b0;
    end
  end

  sample_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (entry),
    .pop   (fifo_rd),
    .rdata (fifo_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count),
    .drop  (drop)
  );
endmodule

// File: tb/tb_sample_collector.sv
// Directed bench for sample_collector with 4 pins and a 4-deep FIFO; expected
// entries are queued as sweeps are driven and compared as the host pops them.
module tb_sample_collector;
  localparam int NP = 4;
  localparam int FD = 4;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0;
  logic          fifo_rd = 1'b0, clear_overflow = 1'b0;
  logic [15:0]   poll_period = 16'd10;
  logic [NP-1:0] pin_mask = '1;
  logic [18:0]   pc_addr;
  logic          pc_rd;
  logic [15:0]   pc_data;
  logic [31:0]   fifo_data;
  logic          fifo_empty, overflow, busy;
  logic [2:0]    fifo_count;
  logic [15:0]   exp_ts;
  logic [15:0]   st_a, st_b, st_x;
  logic [15:0]   wts [3] = '{16'hFFFC, 16'h0000, 16'h0004};
  int            n_cmp = 0, n_err = 0;
  logic [31:0]   exp_q [$];

  sample_collector #(.NUM_PINS(NP), .FIFO_DEPTH(FD), .SAMPLE_REG_OFFSET(7)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .poll_period(poll_period), .pin_mask(pin_mask),
    .pc_addr(pc_addr), .pc_rd(pc_rd), .pc_data(pc_data),
    .fifo_rd(fifo_rd), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_count(fifo_count), .overflow(overflow),
    .clear_overflow(clear_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // pin model: bit0 = pin index bit 0, upper bits noisy to catch bad packing
  assign pc_data = pc_rd ? {15'h2AAA, pc_addr[8]} : 16'h0;

  // reference free-running timestamp
  always @(posedge clk) exp_ts <= reset ? 16'h0 : exp_ts + 16'h1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] ent(input logic [15:0] t, input int k);
    return {t, 8'(k), 7'b0, k[0]};
  endfunction

  task automatic pop_chk(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $error("FAIL %s: scoreboard empty, observed %h expected none", tag, fifo_data);
    end else begin
      e = exp_q.pop_front();
      chk(tag, fifo_data, e);
      chk({tag, "_empty"}, fifo_empty, 1'b0);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      pop_chk("head");
      fifo_rd = 1'b1; tick; fifo_rd = 1'b0;
    end
  endtask

  task automatic run_sweep(input logic [3:0] m, input bit pop_each, input bit keep,
                           output logic [15:0] st);
    st = exp_ts;
    for (int k = 0; k < NP; k++) begin
      chk("pc_rd", pc_rd, m[k]);
      chk("pc_addr", pc_addr, 32'({3'b0, 8'(k), 8'h07}));
      if (pop_each) begin pop_chk("head_full"); fifo_rd = 1'b1; end
      if (m[k] && keep) exp_q.push_back(ent(st, k));
      tick;
    end
    fifo_rd = 1'b0;
  endtask

  task automatic wait_sweep();
    int n = 0;
    while (!pc_rd && n < 40) begin tick; n++; end
    chk("wait_sweep", pc_rd, 1'b1);
  endtask

  initial begin
    tick; tick;
    chk("rst_pc_addr", pc_addr, 0);
    chk("rst_pc_rd", pc_rd, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", fifo_data, 0);
    reset = 1'b0; tick;

    // full mask, period 10, sweep timing and timestamps
    pin_mask = 4'hF; poll_period = 16'd10;
    start = 1'b1; tick; start = 1'b0;
    run_sweep(4'hF, 0, 1, st_a);
    chk("cnt_a", fifo_count, 4);
    chk("busy_wait", busy, 1);
    drain(4);
    chk("empty_a", fifo_empty, 1);
    wait_sweep();
    chk("ts_step", exp_ts, 32'(16'(st_a + 16'd14)));
    run_sweep(4'hF, 0, 1, st_b);
    pin_mask = 4'h5;
    drain(4);
    wait_sweep();
    run_sweep(4'h5, 0, 1, st_x);
    chk("cnt_mask", fifo_count, 2);
    stop = 1'b1; tick; stop = 1'b0;
    chk("busy_stop_wait", busy, 0);
    drain(2);

    // overflow: second sweep dropped, then full push+pop
    pin_mask = 4'hF;
    start = 1'b1; tick; start = 1'b0;
    run_sweep(4'hF, 0, 1, st_x);
    chk("cnt_full", fifo_count, 4);
    chk("ovf_before", overflow, 0);
    wait_sweep();
    run_sweep(4'hF, 0, 0, st_x);
    chk("cnt_sat", fifo_count, 4);
    chk("ovf_set", overflow, 1);
    clear_overflow = 1'b1; tick; clear_overflow = 1'b0;
    chk("ovf_clr", overflow, 0);
    wait_sweep();
    run_sweep(4'hF, 1, 1, st_x);
    chk("cnt_pushpop", fifo_count, 4);
    chk("ovf_pushpop", overflow, 0);
    stop = 1'b1; tick; stop = 1'b0;
    drain(4);
    chk("empty_b", fifo_empty, 1);

    // stop during idx 2; pop on empty FIFO ignored at idx 0
    start = 1'b1; tick; start = 1'b0;
    st_x = exp_ts;
    chk("stop_rd0", pc_rd, 1);
    fifo_rd = 1'b1; exp_q.push_back(ent(st_x, 0)); tick; fifo_rd = 1'b0;
    chk("cnt_emptypop", fifo_count, 1);
    exp_q.push_back(ent(st_x, 1)); tick;
    chk("stop_rd2", pc_rd, 1);
    chk("stop_addr2", pc_addr, 32'h0207);
    stop = 1'b1; tick; stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_pc_rd", pc_rd, 0);
    chk("stop_cnt", fifo_count, 2);
    drain(2);
    start = 1'b1; stop = 1'b1; tick; start = 1'b0; stop = 1'b0;
    chk("startstop_busy", busy, 0);
    tick;
    chk("startstop_rd", pc_rd, 0);

    // reset mid-sweep flushes
    start = 1'b1; tick; start = 1'b0; tick; tick;
    reset = 1'b1; tick; reset = 1'b0;
    chk("flush_cnt", fifo_count, 0);
    chk("flush_empty", fifo_empty, 1);
    chk("flush_busy", busy, 0);
    chk("flush_data", fifo_data, 0);

    // back-to-back sweeps across the timestamp wrap
    begin
      int n = 0;
      while (exp_ts != 16'hFFFB && n < 70000) begin tick; n++; end
    end
    chk("ts_reach", exp_ts, 32'hFFFB);
    poll_period = 16'd0;
    start = 1'b1; tick; start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk("b2b_rd", pc_rd, 1);
      chk("b2b_addr", pc_addr, 32'({3'b0, 8'(k % 4), 8'h07}));
      if (k > 0) pop_chk("b2b_head");
      fifo_rd = 1'b1;
      exp_q.push_back(ent(wts[k / 4], k % 4));
      tick;
    end
    fifo_rd = 1'b0;
    stop = 1'b1; tick; stop = 1'b0;
    drain(1);
    chk("empty_end", fifo_empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
